// File: rtl/idct_vecrot_if.sv
// Stream interface of the IDCT input vector-rotation block: real coefficient
// sink side, complex sample source side and the frame-error flag.
interface idct_vecrot_if #(
  parameter int unsigned wDataIn  = 18,
  parameter int unsigned wDataOut = 18
);
  logic [11:0]         fftpts_in;
  logic                sink_valid;
  logic                sink_sop;
  logic                sink_eop;
  logic                sink_ready;
  logic [wDataIn-1:0]  sink_data;
  logic                source_valid;
  logic                source_sop;
  logic                source_eop;
  logic [wDataOut-1:0] source_real;
  logic [wDataOut-1:0] source_imag;
  logic                frame_err;

  modport master (
    output fftpts_in, sink_valid, sink_sop, sink_eop, sink_data,
    input  sink_ready, source_valid, source_sop, source_eop, source_real, source_imag,
    input  frame_err
  );

  modport slave (
    input  fftpts_in, sink_valid, sink_sop, sink_eop, sink_data,
    output sink_ready, source_valid, source_sop, source_eop, source_real, source_imag,
    output frame_err
  );
endinterface

// File: rtl/idct_vecrot.sv
// IDCT input pre-rotation: buffers N real coefficients X(k), then streams
// Y(k) = sqrt(2)*(X(k) - jX(N-k))*exp(j*pi*k/2N), Y(0) = X(0).
module idct_vecrot #(
  parameter int unsigned wDataIn  = 18,
  parameter int unsigned wCoeff   = 18,
  parameter int unsigned wDataOut = 18
) (
  input logic          clk,
  input logic          rst_sync,
  idct_vecrot_if.slave io_vr
);

  localparam int unsigned RamDepth = 2048;
  localparam int unsigned wProd    = wDataIn + wCoeff + 1;
  localparam int unsigned wSum     = wDataIn + wCoeff + 2;

  localparam longint PiQ30    = 64'sd3373259426;
  localparam longint Sqrt2Q30 = 64'sd1518500250;

  localparam logic [wCoeff-1:0]      Unity   = wCoeff'(65536);
  localparam logic signed [wSum-1:0] RndHalf = wSum'(32768);
  localparam logic signed [wSum-1:0] OutMax  =
    {{(wSum-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [wSum-1:0] OutMin  =
    {{(wSum-wDataOut+1){1'b1}}, {(wDataOut-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  // sqrt(2)*cos/sin(pi*idx/4096) in unsigned Q16, by fixed-point Taylor series
  function automatic logic [wCoeff-1:0] rot_coef(input int idx, input logic is_sin);
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint den;
    longint prod;
    x    = (PiQ30 * longint'(idx)) >>> 12;
    x2   = (x * x) >>> 30;
    term = is_sin ? x : (64'sd1 <<< 30);
    acc  = term;
    for (longint n = 1; n <= 12; n++) begin
      if (is_sin) den = (64'sd2 * n) * (64'sd2 * n + 64'sd1);
      else        den = (64'sd2 * n - 64'sd1) * (64'sd2 * n);
      term = -(((term * x2) >>> 30) / den);
      acc  = acc + term;
    end
    if (acc < 0) acc = 0;
    prod = (acc * Sqrt2Q30 + (64'sd1 <<< 43)) >>> 44;
    return wCoeff'(prod);
  endfunction

  function automatic logic [wDataOut-1:0] sat_out(input logic signed [wSum-1:0] v);
    logic [wDataOut-1:0] r;
    if (v > OutMax)      r = {1'b0, {(wDataOut-1){1'b1}}};
    else if (v < OutMin) r = {1'b1, {(wDataOut-1){1'b0}}};
    else                 r = v[wDataOut-1:0];
    return r;
  endfunction

  logic [wCoeff-1:0] w_cos_tab [RamDepth];
  logic [wCoeff-1:0] w_sin_tab [RamDepth];

  for (genvar gi = 0; gi < RamDepth; gi++) begin : g_rom
    localparam logic [wCoeff-1:0] CosVal = rot_coef(gi, 1'b0);
    localparam logic [wCoeff-1:0] SinVal = rot_coef(gi, 1'b1);
    assign w_cos_tab[gi] = CosVal;
    assign w_sin_tab[gi] = SinVal;
  end

  state_e      r_state, w_state_d;
  logic [11:0] r_n, w_n_d;
  logic [2:0]  r_shift, w_shift_d;
  logic [11:0] r_wr_cnt, w_wr_cnt_d;
  logic [11:0] r_k, w_k_d;
  logic        r_frame_err;

  logic        w_accept;
  logic        w_we;
  logic [10:0] w_waddr;
  logic        w_err;
  logic        w_issue;
  logic [11:0] w_dec_n;
  logic [2:0]  w_dec_shift;
  logic [10:0] w_addr_a;
  logic [10:0] w_addr_b;
  logic [10:0] w_rom_addr;

  assign io_vr.sink_ready = !rst_sync && (r_state != StRead);
  assign w_accept         = io_vr.sink_valid && io_vr.sink_ready;

  // Unsupported lengths fall back to the longest transform
  always_comb begin
    w_dec_n     = 12'd2048;
    w_dec_shift = 3'd0;
    case (io_vr.fftpts_in)
      12'd32:   begin w_dec_n = 12'd32;   w_dec_shift = 3'd6; end
      12'd64:   begin w_dec_n = 12'd64;   w_dec_shift = 3'd5; end
      12'd128:  begin w_dec_n = 12'd128;  w_dec_shift = 3'd4; end
      12'd256:  begin w_dec_n = 12'd256;  w_dec_shift = 3'd3; end
      12'd512:  begin w_dec_n = 12'd512;  w_dec_shift = 3'd2; end
      12'd1024: begin w_dec_n = 12'd1024; w_dec_shift = 3'd1; end
      default:  begin w_dec_n = 12'd2048; w_dec_shift = 3'd0; end
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_n_d      = r_n;
    w_shift_d  = r_shift;
    w_wr_cnt_d = r_wr_cnt;
    w_k_d      = r_k;
    w_we       = 1'b0;
    w_waddr    = r_wr_cnt[10:0];
    w_err      = 1'b0;
    w_issue    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept && io_vr.sink_sop) begin
          w_state_d  = StWrite;
          w_n_d      = w_dec_n;
          w_shift_d  = w_dec_shift;
          w_we       = 1'b1;
          w_waddr    = 11'd0;
          w_wr_cnt_d = 12'd1;
          w_err      = io_vr.sink_eop;
        end
      end
      StWrite: begin
        if (w_accept) begin
          w_we = 1'b1;
          if (io_vr.sink_sop) begin
            w_n_d      = w_dec_n;
            w_shift_d  = w_dec_shift;
            w_waddr    = 11'd0;
            w_wr_cnt_d = 12'd1;
            w_err      = io_vr.sink_eop;
          end else begin
            w_wr_cnt_d = r_wr_cnt + 12'd1;
            if (r_wr_cnt == r_n - 12'd1) begin
              w_state_d = StRead;
              w_k_d     = 12'd0;
              w_err     = !io_vr.sink_eop;
            end else begin
              w_err = io_vr.sink_eop;
            end
          end
        end
      end
      StRead: begin
        w_issue = 1'b1;
        w_k_d   = r_k + 12'd1;
        if (r_k == r_n - 12'd1) begin
          w_state_d  = StIdle;
          w_wr_cnt_d = 12'd0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_state     <= StIdle;
      r_n         <= 12'd0;
      r_shift     <= 3'd0;
      r_wr_cnt    <= 12'd0;
      r_k         <= 12'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_n         <= w_n_d;
      r_shift     <= w_shift_d;
      r_wr_cnt    <= w_wr_cnt_d;
      r_k         <= w_k_d;
      r_frame_err <= w_err;
    end
  end

  // B address wraps to 0 at k = 0; that operand is zeroed downstream
  assign w_addr_a   = r_k[10:0];
  assign w_addr_b   = r_n[10:0] - r_k[10:0];
  assign w_rom_addr = r_k[10:0] << r_shift;

  logic [wDataIn-1:0] r_ram [RamDepth];
  logic [wDataIn-1:0] r_a, r_b;
  logic [wCoeff-1:0]  r_cos, r_sin;
  logic               r_v1, r_sop1, r_eop1;

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_waddr] <= io_vr.sink_data;
    r_a   <= r_ram[w_addr_a];
    r_b   <= r_ram[w_addr_b];
    r_cos <= w_cos_tab[w_rom_addr];
    r_sin <= w_sin_tab[w_rom_addr];
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_v1   <= 1'b0;
      r_sop1 <= 1'b0;
      r_eop1 <= 1'b0;
    end else begin
      r_v1   <= w_issue;
      r_sop1 <= w_issue && (r_k == 12'd0);
      r_eop1 <= w_issue && (r_k == r_n - 12'd1);
    end
  end

  logic [wDataIn-1:0]       w_b_op;
  logic [wCoeff-1:0]        w_c_op, w_s_op;
  logic signed [wProd-1:0]  w_a_x, w_b_x, w_c_x, w_s_x;
  logic signed [wProd-1:0]  r_ac, r_bs, r_as, r_bc;
  logic                     r_v2, r_sop2, r_eop2;

  // k = 0 passes X(0) straight through: c = 1.0, s = 0, b = 0
  assign w_b_op = r_sop1 ? '0    : r_b;
  assign w_c_op = r_sop1 ? Unity : r_cos;
  assign w_s_op = r_sop1 ? '0    : r_sin;

  assign w_a_x = {{(wProd-wDataIn){r_a[wDataIn-1]}}, r_a};
  assign w_b_x = {{(wProd-wDataIn){w_b_op[wDataIn-1]}}, w_b_op};
  assign w_c_x = {{(wProd-wCoeff){1'b0}}, w_c_op};
  assign w_s_x = {{(wProd-wCoeff){1'b0}}, w_s_op};

  always_ff @(posedge clk) begin
    r_ac <= w_a_x * w_c_x;
    r_bs <= w_b_x * w_s_x;
    r_as <= w_a_x * w_s_x;
    r_bc <= w_b_x * w_c_x;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_v2   <= 1'b0;
      r_sop2 <= 1'b0;
      r_eop2 <= 1'b0;
    end else begin
      r_v2   <= r_v1;
      r_sop2 <= r_sop1;
      r_eop2 <= r_eop1;
    end
  end

  logic signed [wSum-1:0] w_sum_re, w_sum_im, w_re_sh, w_im_sh;
  logic                   r_v3, r_sop3, r_eop3;
  logic [wDataOut-1:0]    r_out_re, r_out_im;

  assign w_sum_re = {r_ac[wProd-1], r_ac} + {r_bs[wProd-1], r_bs};
  assign w_sum_im = {r_as[wProd-1], r_as} - {r_bc[wProd-1], r_bc};
  assign w_re_sh  = (w_sum_re + RndHalf) >>> 16;
  assign w_im_sh  = (w_sum_im + RndHalf) >>> 16;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_v3     <= 1'b0;
      r_sop3   <= 1'b0;
      r_eop3   <= 1'b0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else begin
      r_v3     <= r_v2;
      r_sop3   <= r_sop2;
      r_eop3   <= r_eop2;
      r_out_re <= r_v2 ? sat_out(w_re_sh) : '0;
      r_out_im <= r_v2 ? sat_out(w_im_sh) : '0;
    end
  end

  assign io_vr.source_valid = r_v3;
  assign io_vr.source_sop   = r_sop3;
  assign io_vr.source_eop   = r_eop3;
  assign io_vr.source_real  = r_out_re;
  assign io_vr.source_imag  = r_out_im;
  assign io_vr.frame_err    = r_frame_err;

endmodule

// File: tb/tb_idct_vecrot.sv
// Directed bench for idct_vecrot: DC impulse, single bin, saturation, framing,
// unsupported length and mid-frame reset, with hand-computed expectations.
module tb_idct_vecrot;

  logic clk;
  logic rst_sync;

  idct_vecrot_if #(.wDataIn(18), .wDataOut(18)) vr ();

  idct_vecrot #(
    .wDataIn (18),
    .wCoeff  (18),
    .wDataOut(18)
  ) dut (
    .clk     (clk),
    .rst_sync(rst_sync),
    .io_vr   (vr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err;
  int cyc;
  int n_out, n_sop, n_eop, sop_idx, eop_idx, n_ferr;
  int first_cyc, last_cyc, last_acc_cyc;
  int o_re [4096];
  int o_im [4096];
  int x    [2048];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One cycle; outputs are captured at the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (vr.source_valid && n_out < 4096) begin
      if (n_out == 0) first_cyc = cyc;
      last_cyc     = cyc;
      o_re[n_out]  = $signed(vr.source_real);
      o_im[n_out]  = $signed(vr.source_imag);
      if (vr.source_sop) begin n_sop++; sop_idx = n_out; end
      if (vr.source_eop) begin n_eop++; eop_idx = n_out; end
      n_out++;
    end
    if (vr.frame_err) n_ferr++;
  endtask

  task automatic clr_cap();
    n_out = 0; n_sop = 0; n_eop = 0; sop_idx = -1; eop_idx = -1; n_ferr = 0;
    first_cyc = 0; last_cyc = 0;
  endtask

  task automatic clear_x();
    for (int i = 0; i < 2048; i++) x[i] = 0;
  endtask

  task automatic send_frame(input int fft, input int len, input int eop_a, input int eop_b);
    vr.fftpts_in = 12'(fft);
    for (int i = 0; i < len; i++) begin
      int g;
      bit acc;
      g = 0;
      acc = 1'b0;
      vr.sink_valid = 1'b1;
      vr.sink_sop   = (i == 0);
      vr.sink_eop   = (i == eop_a) || (i == eop_b);
      vr.sink_data  = 18'(x[i]);
      while (!acc && g < 100) begin
        acc = vr.sink_ready;
        tick();
        g++;
      end
      if (!acc) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    last_acc_cyc  = cyc;
    vr.sink_valid = 1'b0;
    vr.sink_sop   = 1'b0;
    vr.sink_eop   = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int g;
    g = 0;
    while (n_out < n && g < 6000) begin
      tick();
      g++;
    end
    repeat (6) tick();
    chk("out_count", n_out, n);
  endtask

  function automatic int count_nz(input int skip_a, input int skip_b);
    int c;
    c = 0;
    for (int k = 0; k < n_out; k++)
      if (k != skip_a && k != skip_b && (o_re[k] != 0 || o_im[k] != 0)) c++;
    return c;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int rl, g, bad;
    n_vec = 0; n_err = 0; cyc = 0;
    clr_cap();
    clear_x();
    vr.fftpts_in  = 12'd32;
    vr.sink_valid = 1'b0;
    vr.sink_sop   = 1'b0;
    vr.sink_eop   = 1'b0;
    vr.sink_data  = '0;
    rst_sync      = 1'b1;
    repeat (3) tick();
    chk("rst_ready", vr.sink_ready, 0);
    chk("rst_valid", vr.source_valid, 0);
    chk("rst_real", vr.source_real, 0);
    chk("rst_ferr", vr.frame_err, 0);
    rst_sync = 1'b0;
    tick();
    chk("idle_ready", vr.sink_ready, 1);

    // DC impulse
    clear_x(); x[0] = 1000;
    clr_cap();
    send_frame(32, 32, 31, -1);
    wait_out(32);
    chk("dc_y0_re", o_re[0], 1000);
    chk("dc_y0_im", o_im[0], 0);
    chk("dc_rest_zero", count_nz(0, 0), 0);
    chk("dc_sop_cnt", n_sop, 1);
    chk("dc_sop_idx", sop_idx, 0);
    chk("dc_eop_cnt", n_eop, 1);
    chk("dc_eop_idx", eop_idx, 31);
    chk("dc_contig", last_cyc - first_cyc, 31);
    chk("dc_latency", first_cyc - last_acc_cyc, 3);
    chk("dc_ferr", n_ferr, 0);

    // Single bin X(1)
    clear_x(); x[1] = 1000;
    clr_cap();
    send_frame(32, 32, 31, -1);
    wait_out(32);
    chk("bin_y1_re", o_re[1], 1413);
    chk("bin_y1_im", o_im[1], 69);
    chk("bin_y31_re", o_re[31], 1413);
    chk("bin_y31_im", o_im[31], -69);
    chk("bin_rest_zero", count_nz(1, 31), 0);

    // Saturation
    clear_x();
    for (int i = 0; i < 32; i++) x[i] = 131071;
    clr_cap();
    send_frame(32, 32, 31, -1);
    wait_out(32);
    chk("sat_y16_re", o_re[16], 131071);
    chk("sat_y16_im", o_im[16], 0);
    chk("sat_y0_re", o_re[0], 131071);
    chk("sat_y1_im", o_im[1], -131072);
    bad = 0;
    for (int k = 0; k < n_out; k++) if (o_re[k] != 131071) bad++;
    chk("sat_re_all", bad, 0);

    // Early eop plus sink_valid held through READ
    clear_x(); x[0] = 500;
    clr_cap();
    send_frame(32, 32, 20, 31);
    vr.sink_valid = 1'b1;
    rl = 0; g = 0;
    while (!vr.sink_ready && g < 200) begin
      vr.sink_data = 18'($urandom);
      tick();
      rl++;
      g++;
    end
    vr.sink_valid = 1'b0;
    chk("frm_ready_low", rl, 32);
    wait_out(32);
    chk("frm_ferr", n_ferr, 1);
    chk("frm_y0_re", o_re[0], 500);
    chk("frm_rest_zero", count_nz(0, 0), 0);

    // Unsupported length falls back to N = 2048, step 1
    clear_x(); x[1] = 1000;
    clr_cap();
    send_frame(100, 2048, 2047, -1);
    wait_out(2048);
    chk("n2k_y1_re", o_re[1], 1414);
    chk("n2k_y1_im", o_im[1], 1);
    chk("n2k_y2047_re", o_re[2047], 1414);
    chk("n2k_y2047_im", o_im[2047], -1);
    chk("n2k_rest_zero", count_nz(1, 2047), 0);
    chk("n2k_eop_idx", eop_idx, 2047);
    chk("n2k_contig", last_cyc - first_cyc, 2047);
    chk("n2k_ferr", n_ferr, 0);

    // Reset at k = 10 of a READ phase
    clear_x();
    for (int i = 0; i < 32; i++) x[i] = 5000;
    clr_cap();
    send_frame(32, 32, 31, -1);
    repeat (10) tick();
    rst_sync = 1'b1;
    tick();
    chk("rmid_valid", vr.source_valid, 0);
    chk("rmid_ready", vr.sink_ready, 0);
    tick();
    rst_sync = 1'b0;
    tick();
    chk("rmid_idle_ready", vr.sink_ready, 1);
    clr_cap();
    repeat (10) tick();
    chk("rmid_no_residue", n_out, 0);
    clear_x(); x[3] = 2000;
    send_frame(64, 64, 63, -1);
    wait_out(64);
    chk("n64_y0_re", o_re[0], 0);
    chk("n64_y3_re", o_re[3], 2821);
    chk("n64_y3_im", o_im[3], 208);
    chk("n64_y61_re", o_re[61], 2821);
    chk("n64_y61_im", o_im[61], -208);
    chk("n64_rest_zero", count_nz(3, 61), 0);
    chk("n64_ferr", n_ferr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
